// File: rtl/pc_fetch.sv
// Instruction-fetch front end: owns the PC, drives the instruction ROM and registers
// the fetched pc/inst pair into the IF/ID stage with stall, redirect and flush handling.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if,
    input  logic        stall_id,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic [31:0] inst_i,
    output logic [31:0] pc,
    output logic        ce,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_adel
);

    logic        r_ce;
    logic [31:0] r_pc;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_inst;
    logic        r_id_adel;
    logic        w_misaligned;
    logic [31:0] w_pc_seq;

    assign w_misaligned = |r_pc[1:0];
    // Plain add keeps the low bits, so a misaligned stream stays misaligned until flush.
    assign w_pc_seq     = r_pc + 32'(PC_STEP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ce <= 1'b0;
            r_pc <= RESET_PC;
        end else begin
            r_ce <= 1'b1;
            // The enable edge itself leaves the PC at RESET_PC so it is fetched first.
            if (r_ce) begin
                if (flush) begin
                    r_pc <= new_pc;
                end else if (!stall_if) begin
                    if (branch_flag_i) begin
                        r_pc <= branch_target_i;
                    end else begin
                        r_pc <= w_pc_seq;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_id_pc   <= 32'h0;
            r_id_inst <= 32'h0;
            r_id_adel <= 1'b0;
        end else if (!r_ce || flush || (stall_if && !stall_id)) begin
            r_id_pc   <= 32'h0;
            r_id_inst <= 32'h0;
            r_id_adel <= 1'b0;
        end else if (!stall_if) begin
            r_id_pc   <= r_pc;
            r_id_inst <= w_misaligned ? 32'h0 : inst_i;
            r_id_adel <= w_misaligned;
        end
    end

    assign pc      = r_pc;
    assign ce      = r_ce;
    assign id_pc   = r_id_pc;
    assign id_inst = r_id_inst;
    assign id_adel = r_id_adel;

endmodule

// File: tb/tb_pc_fetch.sv
// Randomized bench for pc_fetch: a cycle-level reference model of the fetch rules is
// stepped alongside the DUT, with directed scenarios for the corner cases.
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_if = 1'b0;
    logic        stall_id = 1'b0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_i = 32'h0;
    logic        flush = 1'b0;
    logic [31:0] new_pc = 32'h0;
    logic [31:0] inst_i;
    logic [31:0] pc;
    logic        ce;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_adel;

    logic [31:0] rom [256];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic        m_ce;
    logic [31:0] m_pc;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_inst;
    logic        m_id_adel;

    pc_fetch #(
        .RESET_PC(32'h0000_0000),
        .PC_STEP (4)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .stall_if       (stall_if),
        .stall_id       (stall_id),
        .branch_flag_i  (branch_flag_i),
        .branch_target_i(branch_target_i),
        .flush          (flush),
        .new_pc         (new_pc),
        .inst_i         (inst_i),
        .pc             (pc),
        .ce             (ce),
        .id_pc          (id_pc),
        .id_inst        (id_inst),
        .id_adel        (id_adel)
    );

    always #5 clk = ~clk;

    assign inst_i = rom[pc[9:2]];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ce      = 1'b0;
        m_pc      = 32'h0;
        m_id_pc   = 32'h0;
        m_id_inst = 32'h0;
        m_id_adel = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".ce"},      32'(ce),      32'(m_ce));
        check_eq({tag, ".pc"},      pc,           m_pc);
        check_eq({tag, ".id_pc"},   id_pc,        m_id_pc);
        check_eq({tag, ".id_inst"}, id_inst,      m_id_inst);
        check_eq({tag, ".id_adel"}, 32'(id_adel), 32'(m_id_adel));
    endtask

    // Apply one cycle of inputs, advance the model by the fetch rules, compare after the edge.
    task automatic step(input logic s_if, input logic s_id, input logic br,
                        input logic [31:0] tgt, input logic fl, input logic [31:0] npc,
                        input string tag);
        logic [31:0] nx_pc;
        logic [31:0] nx_id_pc;
        logic [31:0] nx_id_inst;
        logic        nx_id_adel;
        logic        bad;
        stall_if        = s_if;
        stall_id        = s_id;
        branch_flag_i   = br;
        branch_target_i = tgt;
        flush           = fl;
        new_pc          = npc;

        bad        = (m_pc % 4) != 0;
        nx_pc      = m_pc;
        nx_id_pc   = m_id_pc;
        nx_id_inst = m_id_inst;
        nx_id_adel = m_id_adel;
        if (m_ce) begin
            if (fl)       nx_pc = npc;
            else if (s_if) nx_pc = m_pc;
            else if (br)  nx_pc = tgt;
            else          nx_pc = m_pc + 32'd4;
        end
        if (!m_ce || fl || (s_if && !s_id)) begin
            nx_id_pc   = 32'h0;
            nx_id_inst = 32'h0;
            nx_id_adel = 1'b0;
        end else if (!s_if) begin
            nx_id_pc   = m_pc;
            nx_id_inst = bad ? 32'h0 : rom[(m_pc / 4) % 256];
            nx_id_adel = bad;
        end

        @(posedge clk);
        #1;
        m_ce      = 1'b1;
        m_pc      = nx_pc;
        m_id_pc   = nx_id_pc;
        m_id_inst = nx_id_inst;
        m_id_adel = nx_id_adel;
        check_all(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, tag);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = $urandom;
        rom[0] = 32'h2408_0001;

        model_reset();
        #12;
        check_all("reset");
        check_eq("reset.pc_const", pc, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Reset release: id_pc 0 (NOP), 0, 4, 8
        run(1, "rel0");
        check_eq("rel0.id_inst_nop", id_inst, 32'h0);
        run(1, "rel1");
        check_eq("rel1.id_inst_rom0", id_inst, 32'h2408_0001);
        run(2, "rel2");
        check_eq("rel2.id_pc_8", id_pc, 32'h8);

        // Branch decoded from 0x10 while 0x14 is fetched: 0x14 is the delay slot
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10, "br.flush");
        run(1, "br.pre");
        step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0, "br.take");
        check_eq("br.delay_slot", id_pc, 32'h14);
        check_eq("br.pc_target", pc, 32'h40);
        run(2, "br.post");
        check_eq("br.id_pc_44", id_pc, 32'h44);

        // Full stall at pc=0x20 for 3 cycles, with a dropped branch
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20, "stl.flush");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 32'h300, 1'b0, 32'h0, "stl.hold");
        check_eq("stl.pc_frozen", pc, 32'h20);
        run(1, "stl.rel");
        check_eq("stl.resume", pc, 32'h24);

        // Bubble: stall_if only
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, "bub");
        check_eq("bub.id_inst_zero", id_inst, 32'h0);

        // Flush beats branch and stall
        step(1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 32'h180, "fl");
        check_eq("fl.pc_180", pc, 32'h180);

        // Misaligned target
        step(1'b0, 1'b0, 1'b1, 32'h42, 1'b0, 32'h0, "mis.br");
        run(1, "mis.fetch");
        check_eq("mis.adel", 32'(id_adel), 32'h1);
        check_eq("mis.pc_46", pc, 32'h46);

        // 32-bit wrap
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8, "wrap.flush");
        run(2, "wrap");
        check_eq("wrap.pc_0", pc, 32'h0);

        // Randomized traffic with occasional mid-stream resets
        for (int i = 0; i < 400; i++) begin
            logic        s_if;
            logic        s_id;
            logic        br;
            logic        fl;
            logic [31:0] tgt;
            logic [31:0] npc;
            s_if = ($urandom_range(99) < 20);
            s_id = ($urandom_range(99) < 50);
            br   = ($urandom_range(99) < 20);
            fl   = ($urandom_range(99) < 5);
            tgt  = $urandom;
            npc  = $urandom;
            if ($urandom_range(99) < 85) tgt[1:0] = 2'b00;
            if ($urandom_range(99) < 85) npc[1:0] = 2'b00;
            step(s_if, s_id, br, tgt, fl, npc, "rnd");
            if ($urandom_range(99) < 2) begin
                #2;
                rst = 1'b0;
                #1;
                model_reset();
                check_all("rnd.async_rst");
                @(negedge clk);
                rst = 1'b1;
            end
        end

        // Directed asynchronous reset between edges
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b1;
        run(2, "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
